// File: rtl/dmp_timer_periph_if.sv
// DMP peripheral-port request/response bundle.
// The master side is the DMP and the slave side is the peripheral.
interface dmp_timer_periph_if;
    logic        p_sel;
    logic        p_ld;
    logic        p_st;
    logic [2:0]  p_addr;
    logic [31:0] p_dwr;
    logic        p_ldvalid;
    logic [31:0] p_drd;
    logic        p_stall;

    modport master (
        output p_sel, p_ld, p_st, p_addr, p_dwr,
        input  p_ldvalid, p_drd, p_stall
    );
    modport slave (
        input  p_sel, p_ld, p_st, p_addr, p_dwr,
        output p_ldvalid, p_drd, p_stall
    );
endinterface

// File: rtl/dmp_timer_periph.sv
// Timer/scratch peripheral on the DMP port: scratch register, free-running
// counter with compare match and interrupt, and programmable access wait states.
module dmp_timer_periph #(
    parameter int unsigned RESET_WAIT = 0
) (
    input  logic               clk,
    input  logic               rst_a,
    dmp_timer_periph_if.slave  bus,
    output logic               irq_p
);
    typedef enum logic {S_IDLE, S_WAIT} state_e;

    state_e      state_q;
    logic [3:0]  wcnt_q;
    logic        ldvalid_q;
    logic [31:0] drd_q;

    logic [31:0] scratch_q, scratch_d;
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        en_q, en_d, ie_q, ie_d;
    logic [3:0]  wait_q, wait_d;
    logic        match_q, match_d;

    logic        acc, done, do_ld, do_st;
    logic [31:0] rdata;

    always_comb begin
        acc   = bus.p_sel & (bus.p_ld | bus.p_st);
        done  = ((state_q == S_IDLE) & acc & (wait_q == 4'd0)) |
                ((state_q == S_WAIT) & (wcnt_q == 4'd1));
        // Request inputs are held stable through the wait, so sample them at completion.
        do_ld = done & bus.p_sel & bus.p_ld;
        do_st = done & bus.p_sel & bus.p_st;
    end

    always_comb begin
        rdata = 32'd0;
        case (bus.p_addr)
            3'd0:    rdata = scratch_q;
            3'd1:    rdata = count_q;
            3'd2:    rdata = compare_q;
            3'd3:    rdata = {24'd0, wait_q, 2'b00, ie_q, en_q};
            3'd4:    rdata = {31'd0, match_q};
            default: rdata = 32'd0;
        endcase
    end

    always_comb begin
        scratch_d = scratch_q;
        count_d   = en_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        en_d      = en_q;
        ie_d      = ie_q;
        wait_d    = wait_q;
        match_d   = match_q;
        if (do_st) begin
            case (bus.p_addr)
                3'd0: scratch_d = bus.p_dwr;
                3'd1: count_d   = bus.p_dwr;
                3'd2: compare_d = bus.p_dwr;
                3'd3: begin
                    en_d   = bus.p_dwr[0];
                    ie_d   = bus.p_dwr[1];
                    wait_d = bus.p_dwr[7:4];
                end
                3'd4: if (bus.p_dwr[0]) match_d = 1'b0;
                default: ;
            endcase
        end
        // Set takes priority over a same-cycle write-1-to-clear.
        if (en_q && (count_q == compare_q)) match_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            scratch_q <= 32'd0;
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            en_q      <= 1'b0;
            ie_q      <= 1'b0;
            wait_q    <= 4'(RESET_WAIT);
            match_q   <= 1'b0;
        end else begin
            scratch_q <= scratch_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            en_q      <= en_d;
            ie_q      <= ie_d;
            wait_q    <= wait_d;
            match_q   <= match_d;
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q   <= S_IDLE;
            wcnt_q    <= 4'd0;
            ldvalid_q <= 1'b0;
            drd_q     <= 32'd0;
        end else begin
            ldvalid_q <= do_ld;
            drd_q     <= do_ld ? rdata : 32'd0;
            case (state_q)
                S_IDLE: if (acc && (wait_q != 4'd0)) begin
                    state_q <= S_WAIT;
                    wcnt_q  <= wait_q;
                end
                S_WAIT: begin
                    wcnt_q <= wcnt_q - 4'd1;
                    if (wcnt_q == 4'd1) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.p_stall   = rst_a &
                           (((state_q == S_IDLE) & acc & (wait_q != 4'd0)) |
                            ((state_q == S_WAIT) & (wcnt_q != 4'd1)));
    assign bus.p_ldvalid = ldvalid_q;
    assign bus.p_drd     = drd_q;
    assign irq_p         = match_q & ie_q;
endmodule
